// File: rtl/pwm_car_motor_core.sv
// Dual-motor PWM core for an L298N bridge: shared tick/period timebase with
// shadowed period/duty, plus one direction FSM per motor with dead time and brake.
`timescale 1ns/1ps

module pwm_car_motor_fsm #(
  parameter int DEAD_TICKS = 16
) (
  input  logic ACLK,
  input  logic ARESET,
  input  logic run,
  input  logic brake,
  input  logic dir,
  input  logic tick,
  input  logic pwm_raw,
  output logic en,
  output logic pin_a,
  output logic pin_b
);
  // state | meaning
  // IDLE  | run=0 or waiting for brake release, bridge off
  // DRIVE | en follows PWM, pins follow dir_act
  // DEAD  | bridge off for DEAD_TICKS ticks before driving again
  // BRAKE | en=1, both pins high
  localparam int DW = $clog2(DEAD_TICKS + 1);
  localparam logic [DW-1:0] DEAD_LAST = DW'(DEAD_TICKS - 1);

  typedef enum logic [1:0] {IDLE, DRIVE, DEAD, BRAKE} state_t;

  state_t        state, state_n;
  logic          dir_act, dir_act_n;
  logic [DW-1:0] dead_cnt, dead_cnt_n;
  logic          en_n, pin_a_n, pin_b_n;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state    <= IDLE;
      dir_act  <= 1'b0;
      dead_cnt <= '0;
      en       <= 1'b0;
      pin_a    <= 1'b0;
      pin_b    <= 1'b0;
    end else begin
      state    <= state_n;
      dir_act  <= dir_act_n;
      dead_cnt <= dead_cnt_n;
      en       <= en_n;
      pin_a    <= pin_a_n;
      pin_b    <= pin_b_n;
    end
  end

  always_comb begin
    state_n    = state;
    dir_act_n  = dir_act;
    dead_cnt_n = dead_cnt;
    if (!run) begin
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (!brake) begin
            state_n   = DRIVE;
            dir_act_n = dir;
          end
        end
        DRIVE: begin
          if (brake) begin
            state_n = BRAKE;
          end else if (dir != dir_act) begin
            state_n    = DEAD;
            dead_cnt_n = '0;
          end
        end
        DEAD: begin
          // only the tick count ends dead time; dir wobble inside it is ignored
          if (brake) begin
            state_n = BRAKE;
          end else if (tick) begin
            if (dead_cnt == DEAD_LAST) begin
              state_n   = DRIVE;
              dir_act_n = dir;
            end else begin
              dead_cnt_n = dead_cnt + 1'b1;
            end
          end
        end
        BRAKE: begin
          if (!brake) begin
            state_n    = DEAD;
            dead_cnt_n = '0;
          end
        end
        default: state_n = IDLE;
      endcase
    end

    en_n    = 1'b0;
    pin_a_n = 1'b0;
    pin_b_n = 1'b0;
    case (state_n)
      DRIVE: begin
        en_n    = pwm_raw;
        pin_a_n = dir_act_n;
        pin_b_n = ~dir_act_n;
      end
      BRAKE: begin
        en_n    = 1'b1;
        pin_a_n = 1'b1;
        pin_b_n = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

module pwm_car_motor_core #(
  parameter int CNT_W      = 16,
  parameter int DEAD_TICKS = 16
) (
  input  logic        ACLK,
  input  logic        ARESET,
  input  logic [31:0] ctrl_reg,
  input  logic [31:0] prescale_reg,
  input  logic [31:0] period_reg,
  input  logic [31:0] duty_reg,
  output logic        ena,
  output logic        enb,
  output logic        in1,
  output logic        in2,
  output logic        in3,
  output logic        in4,
  output logic        period_tick
);
  logic run, dir_l, dir_r, brake;
  logic [CNT_W-1:0] div_n, per_p, duty_l, duty_r;
  logic unused_reg_bits;

  assign run    = ctrl_reg[0];
  assign dir_l  = ctrl_reg[1];
  assign dir_r  = ctrl_reg[2];
  assign brake  = ctrl_reg[3];
  assign div_n  = prescale_reg[CNT_W-1:0];
  assign per_p  = period_reg[CNT_W-1:0];
  assign duty_l = duty_reg[CNT_W-1:0];
  assign duty_r = duty_reg[16+CNT_W-1:16];
  assign unused_reg_bits = ^{ctrl_reg, prescale_reg, period_reg, duty_reg};

  logic run_q, run_rise, active, tick, wrap, pwm_l, pwm_r;
  logic [CNT_W-1:0] presc_cnt, period_cnt, p_sh, dl_sh, dr_sh;

  // the run rising-edge clock only loads shadows; counting starts one clock later
  assign run_rise    = run & ~run_q;
  assign active      = run & run_q;
  assign tick        = active && (presc_cnt == div_n);
  assign wrap        = tick && (period_cnt == p_sh);
  assign period_tick = wrap;
  assign pwm_l       = active && (period_cnt < dl_sh);
  assign pwm_r       = active && (period_cnt < dr_sh);

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      run_q      <= 1'b0;
      presc_cnt  <= '0;
      period_cnt <= '0;
      p_sh       <= '0;
      dl_sh      <= '0;
      dr_sh      <= '0;
    end else begin
      run_q <= run;
      if (!active) begin
        presc_cnt  <= '0;
        period_cnt <= '0;
      end else begin
        presc_cnt <= tick ? '0 : presc_cnt + 1'b1;
        if (wrap)
          period_cnt <= '0;
        else if (tick)
          period_cnt <= period_cnt + 1'b1;
      end
      if (run_rise || wrap) begin
        p_sh  <= per_p;
        dl_sh <= duty_l;
        dr_sh <= duty_r;
      end
    end
  end

  pwm_car_motor_fsm #(.DEAD_TICKS(DEAD_TICKS)) u_fsm_l (
    .ACLK    (ACLK),
    .ARESET  (ARESET),
    .run     (run),
    .brake   (brake),
    .dir     (dir_l),
    .tick    (tick),
    .pwm_raw (pwm_l),
    .en      (ena),
    .pin_a   (in1),
    .pin_b   (in2)
  );

  pwm_car_motor_fsm #(.DEAD_TICKS(DEAD_TICKS)) u_fsm_r (
    .ACLK    (ACLK),
    .ARESET  (ARESET),
    .run     (run),
    .brake   (brake),
    .dir     (dir_r),
    .tick    (tick),
    .pwm_raw (pwm_r),
    .en      (enb),
    .pin_a   (in3),
    .pin_b   (in4)
  );
endmodule

// File: tb/tb_pwm_car_motor_core.sv
// Scoreboard bench for pwm_car_motor_core: per-cycle expected output vectors
// {period_tick, ena, enb, in1, in2, in3, in4} are queued and compared at negedge.
`timescale 1ns/1ps

module tb_pwm_car_motor_core;
  logic        tb_ACLK = 1'b0;
  logic        tb_ARESET;
  logic [31:0] ctrl_reg, prescale_reg, period_reg, duty_reg;
  logic        ena, enb, in1, in2, in3, in4, period_tick;
  logic [6:0]  outs;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string      tag;
    logic [6:0] val;
  } exp_t;
  exp_t sb_q[$];

  always #5 tb_ACLK = ~tb_ACLK;

  pwm_car_motor_core #(.CNT_W(16), .DEAD_TICKS(16)) dut (
    .ACLK         (tb_ACLK),
    .ARESET       (tb_ARESET),
    .ctrl_reg     (ctrl_reg),
    .prescale_reg (prescale_reg),
    .period_reg   (period_reg),
    .duty_reg     (duty_reg),
    .ena          (ena),
    .enb          (enb),
    .in1          (in1),
    .in2          (in2),
    .in3          (in3),
    .in4          (in4),
    .period_tick  (period_tick)
  );

  assign outs = {period_tick, ena, enb, in1, in2, in3, in4};

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge tb_ACLK);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [6:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb_q.push_back(e);
  endtask

  always @(negedge tb_ACLK) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      check_eq(e.tag, {25'd0, outs}, {25'd0, e.val});
    end
  end

  function automatic logic [6:0] pack(bit pt, bit a, bit b, bit i1, bit i2, bit i3, bit i4);
    return {pt, a, b, i1, i2, i3, i4};
  endfunction

  // N=1, P=9, DL=3 (7 from the period starting at cycle 61), DR=10, both forward
  function automatic logic [6:0] exp_duty(int k);
    int dl;
    bit on;
    dl = (k >= 2 && ((k - 2) / 20) >= 3) ? 7 : 3;
    on = (k >= 2) && (((k - 2) % 20) < 2 * dl);
    return pack((k >= 1) && (k % 20 == 0), on, k >= 2, k >= 1, 1'b0, k >= 1, 1'b0);
  endfunction

  // N=0, P=9, DL=5, DR=10; dir_l flip at 25, brake 60..70 with dir_l flipped back
  function automatic logic [6:0] exp_dir(int k);
    bit pt, pw, a, b, i1, i2, i3, i4;
    pt = (k >= 1) && (k % 10 == 0);
    pw = (k >= 2) && (((k - 2) % 10) < 5);
    if (k < 26)      begin a = pw;   i1 = (k >= 1); i2 = 1'b0; end
    else if (k < 42) begin a = 1'b0; i1 = 1'b0;     i2 = 1'b0; end
    else if (k < 61) begin a = pw;   i1 = 1'b0;     i2 = 1'b1; end
    else if (k < 71) begin a = 1'b1; i1 = 1'b1;     i2 = 1'b1; end
    else if (k < 87) begin a = 1'b0; i1 = 1'b0;     i2 = 1'b0; end
    else             begin a = pw;   i1 = 1'b1;     i2 = 1'b0; end
    if (k < 61)      begin b = (k >= 2); i3 = (k >= 1); i4 = 1'b0; end
    else if (k < 71) begin b = 1'b1;     i3 = 1'b1;     i4 = 1'b1; end
    else if (k < 87) begin b = 1'b0;     i3 = 1'b0;     i4 = 1'b0; end
    else             begin b = 1'b1;     i3 = 1'b1;     i4 = 1'b0; end
    return pack(pt, a, b, i1, i2, i3, i4);
  endfunction

  int pt_cnt, pt_at, ena_hi, enb_lo, enb_lo_at;

  initial begin
    tb_ARESET    = 1'b1;
    ctrl_reg     = 32'h7;
    prescale_reg = 32'd0;
    period_reg   = 32'd9;
    duty_reg     = 32'h000A_0005;

    step(); expect_out("reset_hold", 7'd0);
    step(); expect_out("reset_hold", 7'd0);
    ctrl_reg = 32'h0;
    step(); tb_ARESET = 1'b0; expect_out("reset_release", 7'd0);
    step(); expect_out("idle", 7'd0);

    // duty and mid-period shadow update
    step();
    prescale_reg = 32'd1;
    period_reg   = 32'd9;
    duty_reg     = {16'd10, 16'd3};
    ctrl_reg     = 32'h7;
    for (int k = 0; k <= 100; k++) begin
      if (k > 0) step();
      expect_out($sformatf("duty k=%0d", k), exp_duty(k));
      if (k == 45) duty_reg = {16'd10, 16'd7};
    end

    step(); ctrl_reg = 32'h0;
    step(); expect_out("run_off", 7'd0);
    step(); expect_out("run_off", 7'd0);

    // direction change, dead time, brake with simultaneous flip
    step();
    prescale_reg = 32'd0;
    period_reg   = 32'd9;
    duty_reg     = {16'd10, 16'd5};
    ctrl_reg     = 32'h7;
    for (int k = 0; k <= 110; k++) begin
      if (k > 0) step();
      expect_out($sformatf("dir k=%0d", k), exp_dir(k));
      case (k)
        25: ctrl_reg = 32'h5;
        30: ctrl_reg = 32'h7;
        33: ctrl_reg = 32'h5;
        60: ctrl_reg = 32'hF;
        70: ctrl_reg = 32'h7;
        default: ;
      endcase
    end

    // asynchronous reset while driving, then restart from count 0
    step();
    tb_ARESET = 1'b1;
    #1;
    check_eq("reset_async_imm", {25'd0, outs}, 32'd0);
    expect_out("reset_async", 7'd0);
    step();
    tb_ARESET = 1'b0;
    for (int k = 0; k <= 25; k++) begin
      if (k > 0) step();
      expect_out($sformatf("restart k=%0d", k), exp_dir(k));
    end

    step(); ctrl_reg = 32'h0;
    step(); expect_out("run_off2", 7'd0);

    // P=all-ones wrap, DL=0, DR=all-ones
    step();
    prescale_reg = 32'd0;
    period_reg   = 32'h0000_FFFF;
    duty_reg     = 32'hFFFF_0000;
    ctrl_reg     = 32'h7;
    pt_cnt = 0; pt_at = -1; ena_hi = 0; enb_lo = 0; enb_lo_at = -1;
    for (int k = 1; k <= 65540; k++) begin
      step();
      @(negedge tb_ACLK);
      if (period_tick) begin
        pt_cnt++;
        if (pt_at < 0) pt_at = k;
      end
      if (ena) ena_hi++;
      if (k >= 2 && !enb) begin
        enb_lo++;
        if (enb_lo_at < 0) enb_lo_at = k;
      end
    end
    check_eq("pmax_tick_count", pt_cnt, 32'd1);
    check_eq("pmax_tick_at", pt_at, 32'd65536);
    check_eq("dl0_ena_high", ena_hi, 32'd0);
    check_eq("drmax_enb_low", enb_lo, 32'd1);
    check_eq("drmax_enb_low_at", enb_lo_at, 32'd65537);
    check_eq("pmax_in1", {31'd0, in1}, 32'd1);

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
